osc_freq_monitor: RTL



---
 rtl/osc_freq_monitor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/osc_freq_monitor.sv
// Monitors an asynchronous clock by counting its edges over fixed reference windows.
// Optional build macro OSC_MON_AUTO_RETRY_EN: FAILED retries on its own at the next window close.
module osc_freq_monitor #(
  parameter int WINDOW     = 50000,
  parameter int CNT_W      = 20,
  parameter int MIN_CNT    = 31,
  parameter int MAX_CNT    = 35,
  parameter int GOOD_LIMIT = 4,
  parameter int FAIL_LIMIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mon_clk,
  input  logic             enable,
  input  logic             clear,
  output logic             sel_xtl,
  output logic             clk_good,
  output logic             clk_fail,
  output logic             fail_irq,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_cnt
);

  // state   | meaning
  // IDLE    | disabled, counters and streaks held at zero
  // QUALIFY | collecting consecutive in-range windows
  // RUN     | monitored clock qualified and selected
  // FAILED  | clock lost; waits for clear (or auto retry)

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int GS_W  = $clog2(GOOD_LIMIT + 1);
  localparam int FS_W  = $clog2(FAIL_LIMIT + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    RUN     = 2'd2,
    FAILED  = 2'd3
  } state_t;

  state_t            state;
  logic              s1, s2, s3;
  logic              edge_det;
  logic              counting;
  logic              win_close;
  logic              win_good;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  close_cnt;
  logic [GS_W-1:0]   good_streak;
  logic [FS_W-1:0]   bad_streak;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det  = s2 & ~s3;
  assign counting  = enable && (state != IDLE);
  assign win_close = counting && (win_cnt == WIN_LAST);

  // Closing count includes an edge detected in the closing cycle; saturates at all-ones.
  always_comb begin
    close_cnt = edge_cnt;
    if (edge_det && (edge_cnt != CNT_MAX))
      close_cnt = edge_cnt + 1'b1;
  end

  assign win_good = (close_cnt != CNT_MAX) &&
                    (close_cnt >= CNT_W'(MIN_CNT)) &&
                    (close_cnt <= CNT_W'(MAX_CNT));

  always_ff @(posedge clk) begin
    if (reset || !counting) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      win_cnt  <= win_cnt + 1'b1;
      edge_cnt <= close_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      good_streak <= '0;
      bad_streak  <= '0;
      sel_xtl     <= 1'b0;
      clk_good    <= 1'b0;
      clk_fail    <= 1'b0;
      fail_irq    <= 1'b0;
      meas_valid  <= 1'b0;
      meas_cnt    <= '0;
    end else begin
      fail_irq   <= 1'b0;
      meas_valid <= 1'b0;
      if (clear)
        clk_fail <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        good_streak <= '0;
        bad_streak  <= '0;
        sel_xtl     <= 1'b0;
        clk_good    <= 1'b0;
      end else begin
        if (win_close) begin
          meas_valid <= 1'b1;
          meas_cnt   <= close_cnt;
        end
        case (state)
          IDLE: begin
            state       <= QUALIFY;
            good_streak <= '0;
            bad_streak  <= '0;
          end
          QUALIFY: begin
            if (win_close) begin
              if (!win_good) begin
                good_streak <= '0;
              end else if (good_streak == GS_W'(GOOD_LIMIT - 1)) begin
                state       <= RUN;
                good_streak <= '0;
                bad_streak  <= '0;
                sel_xtl     <= 1'b1;
                clk_good    <= 1'b1;
              end else begin
                good_streak <= good_streak + 1'b1;
              end
            end
          end
          RUN: begin
            if (win_close) begin
              if (win_good) begin
                bad_streak <= '0;
              end else if (bad_streak == FS_W'(FAIL_LIMIT - 1)) begin
                // Set after the clear above so a colliding fail decision wins.
                state      <= FAILED;
                bad_streak <= '0;
                sel_xtl    <= 1'b0;
                clk_good   <= 1'b0;
                clk_fail   <= 1'b1;
                fail_irq   <= 1'b1;
              end else begin
                bad_streak <= bad_streak + 1'b1;
              end
            end
          end
          FAILED: begin
`ifdef OSC_MON_AUTO_RETRY_EN
            if (clear || win_close) begin
`else
            if (clear) begin
`endif
              state       <= QUALIFY;
              good_streak <= '0;
              bad_streak  <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
